// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard unit: E-stage forwarding, load-use/MDU stalls, branch flush, stall counter
module hazard_ctrl #(
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [AW-1:0]    RdE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic             MemReadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MduReqE,
  input  logic             MduDone,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             HazBusy,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic [1:0] {IDLE, LD_STALL, MDU_BUSY} state_t;

  localparam logic [2:0] LD_INIT = 3'(LOAD_STALL - 1);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       lw;

  function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] r);
    return (a == r) && ((ZERO_REG == 0) || (a != '0));
  endfunction

  assign lw = MemReadE && (match(Rs1D, RdE) || match(Rs2D, RdE));

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst_n) begin
      if (RegWriteM && match(Rs1E, RdM))      ForwardAE = 2'b10;
      else if (RegWriteW && match(Rs1E, RdW)) ForwardAE = 2'b01;
      if (RegWriteM && match(Rs2E, RdM))      ForwardBE = 2'b10;
      else if (RegWriteW && match(Rs2E, RdW)) ForwardBE = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    case (state)
      IDLE: begin
        // MDU wins over a simultaneous (illegal) load; a taken branch squashes the load-use victim
        if (MduReqE && !MduDone) begin
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          FlushM   = 1'b1;
          state_nx = MDU_BUSY;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
          if (LOAD_STALL > 1) begin
            state_nx = LD_STALL;
            cnt_nx   = LD_INIT;
          end
        end
      end
      LD_STALL: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = IDLE;
      end
      MDU_BUSY: begin
        if (!MduDone) begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst_n) begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end
  end

  assign HazBusy = rst_n && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n)                   StallCycles <= '0;
    else if (StallF && !(&StallCycles)) StallCycles <= StallCycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int LS = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic MemReadE, RegWriteM, RegWriteW, PCSrcE, MduReqE, MduDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, HazBusy;
  logic [CW-1:0] StallCycles;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.AW(AW), .LOAD_STALL(LS), .ZERO_REG(1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MduReqE(MduReqE), .MduDone(MduDone),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .HazBusy(HazBusy), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic sf, sd, se, fd, fe, fm, busy;
  } outs_t;

  // model state: bubbles still owed to a load, whether an MDU op is pending, stall-cycle tally
  int m_bubbles = 0;
  bit m_mdu     = 0;
  int m_count   = 0;

  function automatic bit same(input logic [AW-1:0] a, input logic [AW-1:0] r);
    return (a == r) && (a != 0);
  endfunction

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (RegWriteM && same(rs, RdM)) return 2'b10;
    if (RegWriteW && same(rs, RdW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic outs_t model();
    outs_t o;
    bit lw;
    o = '0;
    if (!rst_n) begin
      o.fd = 1; o.fe = 1; o.fm = 1;
      return o;
    end
    o.fa = fwd(Rs1E);
    o.fb = fwd(Rs2E);
    lw = MemReadE && (same(Rs1D, RdE) || same(Rs2D, RdE));
    if (m_mdu) begin
      o.busy = 1;
      if (!MduDone) begin o.sf = 1; o.sd = 1; o.se = 1; o.fm = 1; end
    end else if (m_bubbles > 0) begin
      o.busy = 1; o.sf = 1; o.sd = 1; o.fe = 1;
    end else if (MduReqE && !MduDone) begin
      o.sf = 1; o.sd = 1; o.se = 1; o.fm = 1;
    end else if (PCSrcE) begin
      o.fd = 1; o.fe = 1;
    end else if (lw) begin
      o.sf = 1; o.sd = 1; o.fe = 1;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    outs_t o;
    o = model();
    if (!rst_n) begin
      m_bubbles <= 0; m_mdu <= 0; m_count <= 0;
    end else begin
      if (o.sf && m_count < (1 << CW) - 1) m_count <= m_count + 1;
      if (m_mdu) begin
        if (MduDone) m_mdu <= 0;
      end else if (m_bubbles > 0) begin
        m_bubbles <= m_bubbles - 1;
      end else if (MduReqE && !MduDone) begin
        m_mdu <= 1;
      end else if (!PCSrcE && o.sf) begin
        m_bubbles <= LS - 1;
      end
    end
  end

  always @(posedge clk)
    if (rst_n) assert (!(MemReadE && MduReqE));

  always @(negedge clk) begin
    outs_t e, a;
    #2;
    e = model();
    a = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, HazBusy};
    total = total + 1;
    if (a !== e) begin
      bad = bad + 1;
      $display("FAIL outs t=%0t actual=%h expected=%h", $time, a, e);
    end
    total = total + 1;
    if (StallCycles !== CW'(m_count)) begin
      bad = bad + 1;
      $display("FAIL stall_cycles t=%0t actual=%0d expected=%0d", $time, StallCycles, m_count);
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    MemReadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MduReqE = 0; MduDone = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    tick(); tick();
    lit("rst_flush", {FlushD, FlushE, FlushM, StallF, HazBusy}, 5'b11100);
    lit("rst_cnt", StallCycles, 0);
    rst_n = 1;

    // forwarding priority and x0
    @(negedge clk); RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1; #3;
    lit("fwd_m", ForwardAE, 2);
    @(negedge clk); RegWriteM = 0; #3;
    lit("fwd_w", ForwardAE, 1);
    @(negedge clk); Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1; #3;
    lit("fwd_x0", ForwardAE, 0);

    // load-use: three bubbles
    @(negedge clk); idle_in(); MemReadE = 1; RdE = 7; Rs2D = 7; #3;
    lit("lu_c1", {StallF, StallD, FlushE, HazBusy}, 4'b1110);
    tick(); lit("lu_c2", {StallF, StallD, FlushE, HazBusy}, 4'b1111);
    tick(); lit("lu_c3", {StallF, StallD, FlushE, HazBusy}, 4'b1111);
    @(negedge clk); idle_in(); #3;
    lit("lu_done", {StallF, HazBusy}, 0);
    lit("lu_cnt", StallCycles, 3);

    // branch overrides load-use
    @(negedge clk); MemReadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; #3;
    lit("br_lw", {FlushD, FlushE, StallF}, 3'b110);
    @(negedge clk); idle_in(); #3;
    lit("br_idle", HazBusy, 0);

    // MDU busy for four cycles with a stray branch pulse
    @(negedge clk); MduReqE = 1; #3;
    lit("mdu_c1", {StallF, StallD, StallE, FlushM}, 4'b1111);
    @(negedge clk); PCSrcE = 1; #3;
    lit("mdu_br", {StallE, FlushD, HazBusy}, 3'b101);
    @(negedge clk); PCSrcE = 0; #3;
    tick();
    @(negedge clk); MduDone = 1; #3;
    lit("mdu_done", {StallF, StallD, StallE, FlushM, FlushD, FlushE}, 0);
    @(negedge clk); idle_in(); #3;
    lit("mdu_cnt", StallCycles, 7);

    // reset mid-load-stall and mid-MDU
    @(negedge clk); MemReadE = 1; RdE = 3; Rs1D = 3; #3;
    @(negedge clk); idle_in(); rst_n = 0; #3;
    lit("rst_ld", {FlushD, FlushE, FlushM, StallF, HazBusy}, 5'b11100);
    @(negedge clk); rst_n = 1; #3;
    lit("rst_ld_idle", {HazBusy, StallF}, 0);
    lit("rst_ld_cnt", StallCycles, 0);
    @(negedge clk); MduReqE = 1; #3;
    tick();
    @(negedge clk); MduReqE = 0; rst_n = 0; #3;
    lit("rst_mdu", {FlushM, StallE, HazBusy}, 3'b100);
    @(negedge clk); rst_n = 1; #3;
    lit("rst_mdu_idle", {HazBusy, StallE}, 0);

    // saturation
    @(negedge clk); MemReadE = 1; RdE = 9; Rs2D = 9; #3;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk); idle_in(); #3;
    lit("sat", StallCycles, 15);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 59) != 0);
      Rs1D      = AW'($urandom_range(0, 3));
      Rs2D      = AW'($urandom_range(0, 3));
      Rs1E      = AW'($urandom_range(0, 3));
      Rs2E      = AW'($urandom_range(0, 3));
      RdE       = AW'($urandom_range(0, 3));
      RdM       = AW'($urandom_range(0, 3));
      RdW       = AW'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      PCSrcE    = ($urandom_range(0, 5) == 0);
      MduDone   = ($urandom_range(0, 3) == 0);
      MduReqE   = ($urandom_range(0, 9) == 0);
      MemReadE  = !MduReqE && ($urandom_range(0, 2) == 0);
    end
    @(negedge clk); idle_in(); rst_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
